// File: rtl/instr_decoder_queue.sv
// Instruction decoder for the video processor: DEPTH-entry raw instruction FIFO feeding one decoded output stage.
// Optional macro DECODER_ERR_CNT_EN adds a saturating err_count of dropped illegal entries.
module instr_decoder_queue #(
  parameter int DEPTH         = 4,
  parameter int REG_ADDR_W    = 5,
  parameter int SPRITE_ADDR_W = 14,
  parameter int BG_ADDR_W     = 13,
  parameter int MEM_DATA_W    = 9,
  parameter int CP_ADDR_W     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                dataA,
  input  logic [31:0]                dataB,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [3:0]                 out_opcode,
  output logic [REG_ADDR_W-1:0]      out_register,
  output logic [31:0]                out_data,
  output logic [SPRITE_ADDR_W-1:0]   out_sprite_address,
  output logic [BG_ADDR_W-1:0]       out_background_address,
  output logic [MEM_DATA_W-1:0]      out_memory_data,
  output logic [CP_ADDR_W-1:0]       out_cp_address,
  output logic                       illegal_pulse,
  output logic [$clog2(DEPTH):0]     fifo_level
`ifdef DECODER_ERR_CNT_EN
  ,
  output logic [15:0]                err_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [63:0]              mem_q [DEPTH];
  logic [63:0]              entry_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]         level_q, level_d;
  logic                     full, empty, push, load;
  logic [63:0]              head;
  logic [31:0]              head_a, head_b;
  logic                     unused_head;

  logic                     out_valid_q, out_valid_d;
  logic [3:0]               opcode_q, opcode_d;
  logic [REG_ADDR_W-1:0]    register_q, register_d;
  logic [31:0]              data_q, data_d;
  logic [SPRITE_ADDR_W-1:0] sprite_q, sprite_d;
  logic [BG_ADDR_W-1:0]     bg_q, bg_d;
  logic [MEM_DATA_W-1:0]    mem_data_q, mem_data_d;
  logic [CP_ADDR_W-1:0]     cp_q, cp_d;
  logic                     illegal_pulse_q, illegal_pulse_d;

  assign full        = (level_q == LVL_W'(DEPTH));
  assign empty       = (level_q == '0);
  assign head        = mem_q[rd_ptr_q];
  assign head_a      = head[63:32];
  assign head_b      = head[31:0];
  assign unused_head = ^head;

  always_comb begin
    entry_d         = {dataA, dataB};
    push            = in_valid && !full;
    load            = !empty && (!out_valid_q || out_ready);
    wr_ptr_d        = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d        = load ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d         = level_q + LVL_W'(push) - LVL_W'(load);

    out_valid_d     = out_valid_q;
    opcode_d        = opcode_q;
    register_d      = register_q;
    data_d          = data_q;
    sprite_d        = sprite_q;
    bg_d            = bg_q;
    mem_data_d      = mem_data_q;
    cp_d            = cp_q;
    illegal_pulse_d = 1'b0;

    // Any load or consume starts from the idle default; an illegal head leaves it idle,
    // which is correct because a load only happens when the stage is empty or being consumed.
    if (load || (out_valid_q && out_ready)) begin
      out_valid_d = 1'b0;
      opcode_d    = 4'hF;
      register_d  = '0;
      data_d      = '0;
      sprite_d    = '0;
      bg_d        = '0;
      mem_data_d  = '0;
      cp_d        = '0;
    end

    if (load) begin
      case (head_a[3:0])
        4'd0: begin
          out_valid_d = 1'b1;
          opcode_d    = 4'd0;
          register_d  = head_a[4 +: REG_ADDR_W];
          data_d      = head_b;
        end
        4'd1: begin
          out_valid_d = 1'b1;
          opcode_d    = 4'd1;
          sprite_d    = head_a[4 +: SPRITE_ADDR_W];
          mem_data_d  = head_b[MEM_DATA_W-1:0];
        end
        4'd2: begin
          out_valid_d = 1'b1;
          opcode_d    = 4'd2;
          bg_d        = head_a[4 +: BG_ADDR_W];
          mem_data_d  = head_b[MEM_DATA_W-1:0];
        end
        4'd3: begin
          out_valid_d = 1'b1;
          opcode_d    = 4'd3;
          cp_d        = head_a[4 +: CP_ADDR_W];
          data_d      = head_b;
        end
        default: illegal_pulse_d = 1'b1;
      endcase
    end
  end

  // Queue storage holds raw data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= entry_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      level_q         <= '0;
      out_valid_q     <= 1'b0;
      opcode_q        <= 4'hF;
      register_q      <= '0;
      data_q          <= '0;
      sprite_q        <= '0;
      bg_q            <= '0;
      mem_data_q      <= '0;
      cp_q            <= '0;
      illegal_pulse_q <= 1'b0;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      level_q         <= level_d;
      out_valid_q     <= out_valid_d;
      opcode_q        <= opcode_d;
      register_q      <= register_d;
      data_q          <= data_d;
      sprite_q        <= sprite_d;
      bg_q            <= bg_d;
      mem_data_q      <= mem_data_d;
      cp_q            <= cp_d;
      illegal_pulse_q <= illegal_pulse_d;
    end
  end

`ifdef DECODER_ERR_CNT_EN
  logic [15:0] err_count_q, err_count_d;

  always_comb begin
    err_count_d = err_count_q;
    if (illegal_pulse_d && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_count_q <= '0;
    else       err_count_q <= err_count_d;
  end

  assign err_count = err_count_q;
`endif

  assign in_ready               = !full;
  assign fifo_level             = level_q;
  assign out_valid              = out_valid_q;
  assign out_opcode             = opcode_q;
  assign out_register           = register_q;
  assign out_data               = data_q;
  assign out_sprite_address     = sprite_q;
  assign out_background_address = bg_q;
  assign out_memory_data        = mem_data_q;
  assign out_cp_address         = cp_q;
  assign illegal_pulse          = illegal_pulse_q;

endmodule

// File: tb/tb_instr_decoder_queue.sv
// Randomised self-checking bench for instr_decoder_queue against a queue-based decode model.
// Build with DECODER_ERR_CNT_EN defined to also exercise err_count.
module tb_instr_decoder_queue;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, illegal_pulse;
  logic [31:0] dataA, dataB, out_data;
  logic [3:0]  out_opcode, out_cp_address;
  logic [4:0]  out_register;
  logic [13:0] out_sprite_address;
  logic [12:0] out_background_address;
  logic [8:0]  out_memory_data;
  logic [2:0]  fifo_level;
`ifdef DECODER_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int ill_cnt = 0;
  logic [80:0] obs_q[$];
  int          stamp_q[$];
  logic [80:0] cur;

  instr_decoder_queue dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dataA(dataA), .dataB(dataB), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_register(out_register), .out_data(out_data),
    .out_sprite_address(out_sprite_address),
    .out_background_address(out_background_address),
    .out_memory_data(out_memory_data), .out_cp_address(out_cp_address),
    .illegal_pulse(illegal_pulse), .fifo_level(fifo_level)
`ifdef DECODER_ERR_CNT_EN
    , .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  assign cur = {out_opcode, out_register, out_data, out_sprite_address,
                out_background_address, out_memory_data, out_cp_address};

  always @(posedge clk) cyc <= cyc + 1;

  // Records every completed output handshake and every illegal pulse.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      obs_q.push_back(cur);
      stamp_q.push_back(cyc);
    end
    if (illegal_pulse) ill_cnt = ill_cnt + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [80:0] model(input logic [31:0] a, input logic [31:0] b);
    int unsigned op, f;
    logic [80:0] r;
    op = a % 16;
    f  = a / 16;
    r  = {4'hF, 77'd0};
    case (op)
      0: r = {4'd0, 5'(f % 32), b, 14'd0, 13'd0, 9'd0, 4'd0};
      1: r = {4'd1, 5'd0, 32'd0, 14'(f % 16384), 13'd0, 9'(b % 512), 4'd0};
      2: r = {4'd2, 5'd0, 32'd0, 14'd0, 13'(f % 8192), 9'(b % 512), 4'd0};
      3: r = {4'd3, 5'd0, b, 14'd0, 13'd0, 9'd0, 4'(f % 16)};
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_a(input int unsigned op);
    return ($urandom & 32'hFFFF_FFF0) | 32'(op);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, output bit ok);
    in_valid = 1'b1;
    dataA    = a;
    dataB    = b;
    ok       = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (fifo_level == 3'd0 && !out_valid) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dataA = '0; dataB = '0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", in_ready); end
    checks++; if (cur !== {4'hF, 77'd0}) begin fails++; $display("FAIL reset_fields: got %h want %h", cur, {4'hF, 77'd0}); end
    checks++; if (illegal_pulse !== 1'b0) begin fails++; $display("FAIL reset_pulse: got %b want 0", illegal_pulse); end
    for (int i = 0; i < 3; i++) begin
      send(rand_a(0), $urandom, ok);
      checks++; if (!ok) begin fails++; $display("FAIL reset_send%0d: got timeout want accept", i); end
    end
    tick();
    checks++; if (fifo_level !== 3'd2 || out_valid !== 1'b1) begin
      fails++; $display("FAIL prereset_state: got level %0d valid %b want 2 1", fifo_level, out_valid); end
    reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1; dataA = rand_a(1);
    tick();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL midreset_level: got %0d want 0", fifo_level); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid: got %b want 0", out_valid); end
    checks++; if (out_opcode !== 4'hF) begin fails++; $display("FAIL midreset_opcode: got %h want f", out_opcode); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b want 1", in_ready); end
`ifdef DECODER_ERR_CNT_EN
    checks++; if (err_count !== 16'd0) begin fails++; $display("FAIL reset_errcnt: got %h want 0", err_count); end
`endif
  endtask

  task automatic test_single_op0();
    logic [80:0] want;
    want = model(32'h0000_0050, 32'hDEAD_BEEF);
    out_ready = 1'b1;
    in_valid = 1'b1; dataA = 32'h0000_0050; dataB = 32'hDEAD_BEEF;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL op0_early: got valid %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL op0_valid: got %b want 1", out_valid); end
    checks++; if (cur !== want) begin fails++; $display("FAIL op0_fields: got %h want %h", cur, want); end
    checks++; if (out_register !== 5'd5 || out_data !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL op0_regdata: got %0d %h want 5 deadbeef", out_register, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0 || cur !== {4'hF, 77'd0}) begin
      fails++; $display("FAIL op0_idle: got valid %b fields %h want 0 idle", out_valid, cur); end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [31:0] wa[6], wb[6];
    for (int i = 0; i < 6; i++) begin wa[i] = rand_a(1); wb[i] = $urandom; end
    obs_q.delete(); stamp_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(wa[i], wb[i], ok);
      checks++; if (!ok) begin fails++; $display("FAIL bp_send%0d: got timeout want accept", i); end
    end
    in_valid = 1'b1; dataA = wa[5]; dataB = wb[5];
    tick(); tick(); tick();
    checks++; if (in_ready !== 1'b0 || fifo_level !== 3'd4) begin
      fails++; $display("FAIL bp_full: got ready %b level %0d want 0 4", in_ready, fifo_level); end
    checks++; if (out_valid !== 1'b1 || cur !== model(wa[0], wb[0])) begin
      fails++; $display("FAIL bp_hold: got %b %h want 1 %h", out_valid, cur, model(wa[0], wb[0])); end
    out_ready = 1'b1;
    send(wa[5], wb[5], ok);
    checks++; if (!ok) begin fails++; $display("FAIL bp_send5: got timeout want accept"); end
    wait_idle(ok);
    checks++; if (!ok) begin fails++; $display("FAIL bp_drain: got timeout want idle"); end
    checks++; if (obs_q.size() != 6) begin fails++; $display("FAIL bp_count: got %0d want 6", obs_q.size()); end
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== model(wa[i], wb[i])) begin
        fails++; $display("FAIL bp_order%0d: got %h want %h", i, obs_q[i], model(wa[i], wb[i])); end
    end
    for (int i = 1; i < stamp_q.size(); i++) begin
      checks++; if (stamp_q[i] - stamp_q[i-1] != 1) begin
        fails++; $display("FAIL bp_rate%0d: got gap %0d want 1", i, stamp_q[i] - stamp_q[i-1]); end
    end
  endtask

  task automatic test_illegal_drop();
    bit ok;
    int ill0;
    logic [31:0] wa[3], wb[3];
    wa[0] = rand_a(2); wa[1] = rand_a(7); wa[2] = rand_a(2);
    for (int i = 0; i < 3; i++) wb[i] = $urandom;
    obs_q.delete();
    ill0 = ill_cnt;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(wa[i], wb[i], ok);
      checks++; if (!ok) begin fails++; $display("FAIL ill_send%0d: got timeout want accept", i); end
    end
    wait_idle(ok);
    tick();
    checks++; if (!ok) begin fails++; $display("FAIL ill_drain: got timeout want idle"); end
    checks++; if (obs_q.size() != 2) begin fails++; $display("FAIL ill_count: got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[0] !== model(wa[0], wb[0])) begin fails++; $display("FAIL ill_first: got %h want %h", obs_q[0], model(wa[0], wb[0])); end
      checks++; if (obs_q[1] !== model(wa[2], wb[2])) begin fails++; $display("FAIL ill_second: got %h want %h", obs_q[1], model(wa[2], wb[2])); end
    end
    checks++; if (ill_cnt - ill0 != 1) begin fails++; $display("FAIL ill_pulses: got %0d want 1", ill_cnt - ill0); end
`ifdef DECODER_ERR_CNT_EN
    checks++; if (err_count !== 16'd1) begin fails++; $display("FAIL ill_errcnt: got %0d want 1", err_count); end
`endif
  endtask

  task automatic test_wrap_simultaneous();
    bit ok;
    logic [31:0] wa[23], wb[23];
    int lvl_bad;
    for (int i = 0; i < 23; i++) begin wa[i] = ($urandom & 32'hFFFF_FF00) | 32'hA3; wb[i] = $urandom; end
    obs_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(wa[i], wb[i], ok);
      checks++; if (!ok) begin fails++; $display("FAIL wrap_send%0d: got timeout want accept", i); end
    end
    checks++; if (fifo_level !== 3'd2) begin fails++; $display("FAIL wrap_prefill: got %0d want 2", fifo_level); end
    out_ready = 1'b1;
    lvl_bad = 0;
    for (int i = 3; i < 23; i++) begin
      in_valid = 1'b1; dataA = wa[i]; dataB = wb[i];
      tick();
      checks++; if (fifo_level !== 3'd2) begin
        fails++; lvl_bad++; $display("FAIL wrap_level%0d: got %0d want 2", i, fifo_level); end
    end
    in_valid = 1'b0;
    wait_idle(ok);
    checks++; if (!ok) begin fails++; $display("FAIL wrap_drain: got timeout want idle"); end
    checks++; if (obs_q.size() != 23) begin fails++; $display("FAIL wrap_count: got %0d want 23", obs_q.size()); end
    for (int i = 0; i < 23 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== model(wa[i], wb[i])) begin
        fails++; $display("FAIL wrap_order%0d: got %h want %h", i, obs_q[i], model(wa[i], wb[i])); end
    end
    if (obs_q.size() > 0) begin
      checks++; if (obs_q[0][3:0] !== 4'hA) begin fails++; $display("FAIL wrap_cp: got %h want a", obs_q[0][3:0]); end
    end
  endtask

  task automatic test_random();
    bit ok, acc, prev_hold;
    int exp_ill, ill0;
    int unsigned op;
    logic [80:0] exp_q[$];
    logic [80:0] prev_cur;
    obs_q.delete();
    ill0 = ill_cnt; exp_ill = 0; prev_hold = 1'b0; prev_cur = '0;
    in_valid = 1'b0;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (prev_hold) begin
        checks++; if (cur !== prev_cur) begin fails++; $display("FAIL rnd_stable%0d: got %h want %h", c, cur, prev_cur); end
      end
      prev_hold = out_valid && !out_ready;
      prev_cur  = cur;
      tick();
      if (acc) begin
        if (dataA % 16 < 4) exp_q.push_back(model(dataA, dataB));
        else exp_ill++;
        in_valid = 1'b0;
      end
      if (c < 400 && !in_valid && ($urandom % 3 != 0)) begin
        op = ($urandom % 5 == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
        dataA = rand_a(op); dataB = $urandom; in_valid = 1'b1;
      end
      out_ready = (c >= 400) || ($urandom % 4 != 0);
    end
    checks++; if (in_valid !== 1'b0) begin fails++; $display("FAIL rnd_pending: got in_valid %b want 0", in_valid); end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_idle(ok);
    tick();
    checks++; if (!ok) begin fails++; $display("FAIL rnd_drain: got timeout want idle"); end
    checks++; if (obs_q.size() != exp_q.size()) begin fails++; $display("FAIL rnd_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin fails++; $display("FAIL rnd_item%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    checks++; if (ill_cnt - ill0 != exp_ill) begin fails++; $display("FAIL rnd_pulses: got %0d want %0d", ill_cnt - ill0, exp_ill); end
`ifdef DECODER_ERR_CNT_EN
    checks++; if (err_count !== 16'(1 + exp_ill)) begin fails++; $display("FAIL rnd_errcnt: got %0d want %0d", err_count, 1 + exp_ill); end
`endif
  endtask

`ifdef DECODER_ERR_CNT_EN
  task automatic test_saturation();
    bit ok;
    out_ready = 1'b1;
    force dut.err_count_q = 16'hFFFE;
    #2;
    release dut.err_count_q;
    for (int i = 0; i < 3; i++) begin
      send(rand_a(4 + i), $urandom, ok);
      checks++; if (!ok) begin fails++; $display("FAIL sat_send%0d: got timeout want accept", i); end
    end
    tick(); tick();
    checks++; if (err_count !== 16'hFFFF) begin fails++; $display("FAIL sat_errcnt: got %h want ffff", err_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_op0();
    test_backpressure();
    test_illegal_drop();
    test_wrap_simultaneous();
    test_random();
`ifdef DECODER_ERR_CNT_EN
    test_saturation();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
